// File: rtl/lin1d_feeder.sv
// Linear-interpolation feeder: turns a burst of complex samples into a stream
// of adjacent sample pairs (x0, x1) with weights for x0 and x1. A phase
// accumulator mu advances by the step on every accepted pair. The pair window
// slides forward by one input sample each time mu wraps past 1.0.
//
// Weights are Q(SCALE_FRAC) and always sum to exactly 1.0. The weight for x1
// is the top SCALE_FRAC bits of mu. The parameters are legal only when
// SCALE_FRAC <= DATA_WIDTH-2 and SCALE_FRAC <= PHASE_WIDTH.
//
// Handshake rule for both the input and the output side: a beat transfers on
// a rising edge where valid and ready are both high. Valid and data hold
// steady until that edge. In this block, in_tready depends only on the
// state, never on in_tvalid, and out_tvalid never depends on out_tready.
module lin1d_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int SCALE_FRAC  = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PHASE_WIDTH-1:0]    step,
    input  logic [2*DATA_WIDTH-1:0]   in_tdata,
    input  logic                      in_tvalid,
    input  logic                      in_tlast,
    output logic                      in_tready,
    output logic [2*DATA_WIDTH-1:0]   out0_tdata,
    output logic [2*DATA_WIDTH-1:0]   out1_tdata,
    output logic [DATA_WIDTH-1:0]     out_scale0_tdata,
    output logic [DATA_WIDTH-1:0]     out_scale1_tdata,
    output logic                      out_tvalid,
    output logic                      out_tlast,
    input  logic                      out_tready,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        FILL0 = 2'd0,   // waiting for x0 (first sample of a burst)
        FILL1 = 2'd1,   // waiting for x1
        RUN   = 2'd2,   // presenting a pair
        ADV   = 2'd3    // mu wrapped: waiting for the next sample
    } state_t;

    localparam int SHIFT = PHASE_WIDTH - SCALE_FRAC;
    localparam logic [DATA_WIDTH-1:0] SCALE_ONE = DATA_WIDTH'(1) << SCALE_FRAC;

    state_t                    state_q, state_d;
    logic [2*DATA_WIDTH-1:0]   x0_q, x0_d;
    logic [2*DATA_WIDTH-1:0]   x1_q, x1_d;
    logic                      x1_last_q, x1_last_d;
    logic [PHASE_WIDTH-1:0]    mu_q, mu_d;
    // Holds the step with one extra bit, so that step==0 can mean exactly 1.0.
    logic [PHASE_WIDTH:0]      eff_step_q, eff_step_d;

    logic [PHASE_WIDTH:0]      sum;
    logic                      carry;
    logic                      in_fire;
    logic                      out_fire;

    assign sum      = {1'b0, mu_q} + eff_step_q;
    assign carry    = sum[PHASE_WIDTH];
    assign in_fire  = in_tvalid && in_tready;
    assign out_fire = out_tvalid && out_tready;

    // State and datapath registers; reset discards any burst in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL0;
            x0_q       <= '0;
            x1_q       <= '0;
            x1_last_q  <= 1'b0;
            mu_q       <= '0;
            eff_step_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x1_last_q  <= x1_last_d;
            mu_q       <= mu_d;
            eff_step_q <= eff_step_d;
        end
    end

    // Next state and next datapath values. Every register holds unless a beat fires.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        x1_last_d  = x1_last_q;
        mu_d       = mu_q;
        eff_step_d = eff_step_q;
        case (state_q)
            FILL0: begin
                // A lone tlast beat cannot form a pair, so it is dropped.
                if (in_fire && !in_tlast) begin
                    x0_d       = in_tdata;
                    eff_step_d = (step == '0) ? {1'b1, {PHASE_WIDTH{1'b0}}}
                                              : {1'b0, step};
                    mu_d       = '0;
                    state_d    = FILL1;
                end
            end
            FILL1: begin
                if (in_fire) begin
                    x1_d      = in_tdata;
                    x1_last_d = in_tlast;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (out_fire) begin
                    if (!carry) begin
                        mu_d = sum[PHASE_WIDTH-1:0];
                    end else if (!x1_last_q) begin
                        mu_d    = sum[PHASE_WIDTH-1:0];
                        state_d = ADV;
                    end else begin
                        mu_d    = '0;
                        state_d = FILL0;
                    end
                end
            end
            ADV: begin
                if (in_fire) begin
                    x0_d      = x1_q;
                    x1_d      = in_tdata;
                    x1_last_d = in_tlast;
                    state_d   = RUN;
                end
            end
            default: state_d = FILL0;
        endcase
    end

    // Handshake outputs decoded from the current state only.
    always_comb begin
        in_tready  = 1'b0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        case (state_q)
            FILL0, FILL1, ADV: in_tready = 1'b1;
            RUN: begin
                out_tvalid = 1'b1;
                out_tlast  = x1_last_q && carry;
            end
            default: in_tready = 1'b0;
        endcase
    end

    // Pair data and weights come straight from registers, so they stay stable during a stall.
    assign out0_tdata       = x0_q;
    assign out1_tdata       = x1_q;
    assign out_scale1_tdata = DATA_WIDTH'(mu_q >> SHIFT);
    assign out_scale0_tdata = SCALE_ONE - out_scale1_tdata;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_lin1d_feeder.sv
// Directed bench for lin1d_feeder with default parameters (16/16/14).
// A monitor checks every accepted output pair against an expected queue.
module tb_lin1d_feeder;

    localparam logic [31:0] A = 32'h1111_aaaa;
    localparam logic [31:0] B = 32'h2222_bbbb;
    localparam logic [31:0] C = 32'h3333_cccc;

    logic        clk;
    logic        reset;
    logic [15:0] step;
    logic [31:0] in_tdata;
    logic        in_tvalid;
    logic        in_tlast;
    logic        in_tready;
    logic [31:0] out0_tdata;
    logic [31:0] out1_tdata;
    logic [15:0] out_scale0_tdata;
    logic [15:0] out_scale1_tdata;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tready;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int pair_cnt = 0;
    logic [127:0] exp_q[$];

    lin1d_feeder dut (
        .clk              (clk),
        .reset            (reset),
        .step             (step),
        .in_tdata         (in_tdata),
        .in_tvalid        (in_tvalid),
        .in_tlast         (in_tlast),
        .in_tready        (in_tready),
        .out0_tdata       (out0_tdata),
        .out1_tdata       (out1_tdata),
        .out_scale0_tdata (out_scale0_tdata),
        .out_scale1_tdata (out_scale1_tdata),
        .out_tvalid       (out_tvalid),
        .out_tlast        (out_tlast),
        .out_tready       (out_tready),
        .dbg_state        (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pair(input logic [31:0] x0, input logic [31:0] x1,
                                          input logic [15:0] s0, input logic [15:0] s1,
                                          input logic last);
        return {31'b0, x0, x1, s0, s1, last};
    endfunction

    // Scoreboard: every accepted pair must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && out_tvalid && out_tready) begin
            pair_cnt++;
            if (exp_q.size() == 0)
                check("extra_pair", pair(out0_tdata, out1_tdata, out_scale0_tdata,
                                         out_scale1_tdata, out_tlast), 128'd0);
            else
                check("pair", pair(out0_tdata, out1_tdata, out_scale0_tdata,
                                   out_scale1_tdata, out_tlast), exp_q.pop_front());
        end
    end

    // Driver: present one input beat and hold it until accepted
    task automatic send(input logic [31:0] d, input logic l);
        bit done;
        done = 1'b0;
        in_tdata  = d;
        in_tlast  = l;
        in_tvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = in_tready;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", {127'b0, in_tready}, 128'd1);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    // Wait for the block to return to FILL0, then confirm every pair was seen
    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (dbg_state == 2'd0);
        end
        if (!done) check({tag, "_idle_timeout"}, {126'b0, dbg_state}, 128'd0);
        check({tag, "_missing_pairs"}, 128'(exp_q.size()), 128'd0);
        check({tag, "_in_tready"}, {127'b0, in_tready}, 128'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit done;
        reset      = 1'b1;
        step       = 16'h0;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_tvalid", {127'b0, out_tvalid}, 128'd0);
        check("rst_out_tlast",  {127'b0, out_tlast}, 128'd0);
        check("rst_pair", pair(out0_tdata, out1_tdata, out_scale0_tdata, out_scale1_tdata,
                               out_tlast), pair(32'h0, 32'h0, 16'h4000, 16'h0, 1'b0));
        check("rst_state", {126'b0, dbg_state}, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_tready", {127'b0, in_tready}, 128'd1);
        @(posedge clk);
        #1;

        // Half step: two pairs per input advance
        step = 16'h8000;
        exp_q.push_back(pair(A, B, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(A, B, 16'h2000, 16'h2000, 1'b0));
        exp_q.push_back(pair(B, C, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(B, C, 16'h2000, 16'h2000, 1'b1));
        send(A, 1'b0);
        send(B, 1'b0);
        send(C, 1'b1);
        wait_idle("half");

        // step=0 means 1.0: one pair per input sample
        step = 16'h0000;
        exp_q.push_back(pair(A, B, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(B, C, 16'h4000, 16'h0000, 1'b1));
        send(A, 1'b0);
        send(B, 1'b0);
        send(C, 1'b1);
        wait_idle("unity");

        // Quarter step, with a mid-burst step change that must be ignored
        step = 16'h4000;
        exp_q.push_back(pair(A, B, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(A, B, 16'h3000, 16'h1000, 1'b0));
        exp_q.push_back(pair(A, B, 16'h2000, 16'h2000, 1'b0));
        exp_q.push_back(pair(A, B, 16'h1000, 16'h3000, 1'b1));
        send(A, 1'b0);
        step = 16'h1234;
        send(B, 1'b1);
        wait_idle("quarter");

        // Output stall for 10 cycles on the first pair
        step = 16'h8000;
        out_tready = 1'b0;
        send(A, 1'b0);
        send(B, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_pair", pair(out0_tdata, out1_tdata, out_scale0_tdata,
                                     out_scale1_tdata, out_tlast),
                  pair(A, B, 16'h4000, 16'h0000, 1'b0));
            check("stall_vld_rdy", {126'b0, out_tvalid, in_tready}, 128'b10);
            @(posedge clk);
            #1;
        end
        exp_q.push_back(pair(A, B, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(A, B, 16'h2000, 16'h2000, 1'b0));
        exp_q.push_back(pair(B, C, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(B, C, 16'h2000, 16'h2000, 1'b1));
        out_tready = 1'b1;
        send(C, 1'b1);
        wait_idle("stall");

        // A single-beat burst is dropped, then a two-beat burst gives one pair
        step = 16'h0000;
        send(A, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("single_state", {126'b0, dbg_state}, 128'd0);
        check("single_no_out", {127'b0, out_tvalid}, 128'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(pair(A, B, 16'h4000, 16'h0000, 1'b1));
        send(A, 1'b0);
        send(B, 1'b1);
        wait_idle("after_single");

        // Reset in RUN after the second pair
        step = 16'h4000;
        exp_q.push_back(pair(A, B, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(A, B, 16'h3000, 16'h1000, 1'b0));
        begin
            int target;
            target = pair_cnt + 2;
            send(A, 1'b0);
            send(B, 1'b1);
            done = 1'b0;
            for (int i = 0; i < 50 && !done; i++) begin
                @(negedge clk);
                #1;
                done = (pair_cnt >= target);
            end
            if (!done) check("rst_mid_timeout", 128'(pair_cnt), 128'(target));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_vld_last", {126'b0, out_tvalid, out_tlast}, 128'd0);
        check("rst_mid_in_tready", {127'b0, in_tready}, 128'd1);
        check("rst_mid_state", {126'b0, dbg_state}, 128'd0);
        check("rst_mid_scale1", {112'b0, out_scale1_tdata}, 128'd0);
        check("rst_mid_missing", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
        step = 16'h8000;
        exp_q.push_back(pair(C, A, 16'h4000, 16'h0000, 1'b0));
        exp_q.push_back(pair(C, A, 16'h2000, 16'h2000, 1'b1));
        send(C, 1'b0);
        send(A, 1'b1);
        wait_idle("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
